// File: rtl/led_blink_array.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM with runtime period and duty.
// Define LED_BLINK_PWM_EN to enable PWM for mode 11; otherwise mode 11 behaves as BLINK.
module led_blink_array #(
  parameter int CHANNELS       = 4,
  parameter int CNT_WIDTH      = 26,
  parameter int DEFAULT_PERIOD = 25000000,
  parameter int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_chan,
  input  logic [1:0]           cfg_mode,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  output logic [CHANNELS-1:0]  led,
  output logic [CHANNELS-1:0]  tick
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
`ifdef LED_BLINK_PWM_EN
  localparam logic [1:0] MODE_PWM   = 2'b11;
`endif

  logic cfg_ready_reg;
  logic accept;

  assign accept    = cfg_valid && cfg_ready_reg;
  assign cfg_ready = cfg_ready_reg;

  // Ready drops for exactly one cycle after each accepted write.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_ready_reg <= 1'b1;
    end else begin
      cfg_ready_reg <= !accept;
    end
  end

`ifndef LED_BLINK_PWM_EN
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [1:0]           mode_reg;
      logic [CNT_WIDTH-1:0] period_reg;
      logic [CNT_WIDTH-1:0] count_reg;
      logic [CNT_WIDTH-1:0] count_next;
      logic                 led_reg;
      logic                 led_next;
      logic                 tick_reg;
      logic                 tick_next;
      logic                 hit;
      logic                 wrap;
`ifdef LED_BLINK_PWM_EN
      logic [CNT_WIDTH-1:0] duty_reg;
`endif

      assign hit  = accept && (cfg_chan == CH_W'(gi));
      assign wrap = (count_reg == period_reg);

      always_comb begin
        count_next = count_reg;
        led_next   = led_reg;
        tick_next  = 1'b0;
        if (hit) begin
          // A write restarts the channel and suppresses any coincident tick.
          count_next = '0;
          case (cfg_mode)
            MODE_OFF:            led_next = 1'b0;
            MODE_ON, MODE_BLINK: led_next = 1'b1;
            default: begin
`ifdef LED_BLINK_PWM_EN
              led_next = (cfg_duty != '0);
`else
              led_next = 1'b1;
`endif
            end
          endcase
        end else if (mode_reg == MODE_OFF || mode_reg == MODE_ON) begin
          count_next = '0;
`ifdef LED_BLINK_PWM_EN
        end else if (mode_reg == MODE_PWM) begin
          // led tracks the count value it is shown alongside, so a frame starts high.
          count_next = wrap ? '0 : count_reg + CNT_WIDTH'(1);
          led_next   = (count_next < duty_reg);
          tick_next  = wrap;
`endif
        end else begin
          count_next = wrap ? '0 : count_reg + CNT_WIDTH'(1);
          led_next   = wrap ? !led_reg : led_reg;
          tick_next  = wrap;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          mode_reg   <= MODE_BLINK;
          period_reg <= CNT_WIDTH'(DEFAULT_PERIOD);
          count_reg  <= '0;
          led_reg    <= 1'b1;
          tick_reg   <= 1'b0;
`ifdef LED_BLINK_PWM_EN
          duty_reg   <= '0;
`endif
        end else begin
          if (hit) begin
            mode_reg   <= cfg_mode;
            period_reg <= cfg_period;
`ifdef LED_BLINK_PWM_EN
            duty_reg   <= cfg_duty;
`endif
          end
          count_reg <= count_next;
          led_reg   <= led_next;
          tick_reg  <= tick_next;
        end
      end

      assign led[gi]  = led_reg;
      assign tick[gi] = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_led_blink_array.sv
// Directed bench for led_blink_array: reset, blink reprogram, handshake, PWM, write/wrap collision.
// Expected outputs come from closed-form per-channel waveforms keyed on the write time.
module tb_led_blink_array;
  localparam int CHANNELS       = 5;
  localparam int CNT_WIDTH      = 4;
  localparam int DEFAULT_PERIOD = 3;
  localparam int CH_W           = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CH_W-1:0]      cfg_chan;
  logic [1:0]           cfg_mode;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [CNT_WIDTH-1:0] cfg_duty;
  logic [CHANNELS-1:0]  led;
  logic [CHANNELS-1:0]  tick;

  always #5 clk = ~clk;

  led_blink_array #(
    .CHANNELS(CHANNELS),
    .CNT_WIDTH(CNT_WIDTH),
    .DEFAULT_PERIOD(DEFAULT_PERIOD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_mode(cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty(cfg_duty),
    .led(led),
    .tick(tick)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = 0;
  // Per-channel expected waveform: kind 0 constant, 1 blink, 2 pwm.
  int m_kind [CHANNELS];
  int m_val  [CHANNELS];
  int m_p    [CHANNELS];
  int m_d    [CHANNELS];
  int m_t0   [CHANNELS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_kind[i] = 1; m_val[i] = 1; m_p[i] = DEFAULT_PERIOD; m_d[i] = 0; m_t0[i] = t;
    end
  endfunction

  function automatic void model_write(input int ch, input int mode, input int p, input int d);
    m_t0[ch] = t; m_p[ch] = p; m_d[ch] = d; m_val[ch] = 1;
    case (mode)
      0: begin m_kind[ch] = 0; m_val[ch] = 0; end
      1: m_kind[ch] = 0;
      2: m_kind[ch] = 1;
      default: begin
`ifdef LED_BLINK_PWM_EN
        m_kind[ch] = 2;
`else
        m_kind[ch] = 1;
`endif
      end
    endcase
  endfunction

  task automatic check_all();
    logic [CHANNELS-1:0] el;
    logic [CHANNELS-1:0] et;
    for (int i = 0; i < CHANNELS; i++) begin
      int r = t - m_t0[i];
      int f = r % (m_p[i] + 1);
      el[i] = 1'b0;
      et[i] = 1'b0;
      case (m_kind[i])
        0: el[i] = (m_val[i] != 0);
        1: begin
          el[i] = ((r / (m_p[i] + 1)) % 2) == 0;
          et[i] = (r > 0) && (f == 0);
        end
        default: begin
          el[i] = (f < m_d[i]);
          et[i] = (r > 0) && (f == 0);
        end
      endcase
    end
    chk("led", led, el);
    chk("tick", tick, et);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check_all();
    end
  endtask

  task automatic write(input int ch, input int mode, input int p, input int d,
                       input bit hold, output int at);
    cfg_valid  = 1'b1;
    cfg_chan   = CH_W'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = CNT_WIDTH'(p);
    cfg_duty   = CNT_WIDTH'(d);
    for (int w = 0; w < 4 && cfg_ready !== 1'b1; w++) begin
      step();
      check_all();
    end
    chk("ready_before_write", cfg_ready, 1);
    step();
    at = t;
    if (ch < CHANNELS) model_write(ch, mode, p, d);
    chk("ready_after_accept", cfg_ready, 0);
    check_all();
    $display("write ch=%0d mode=%0d P=%0d D=%0d accepted at edge %0d led=%b tick=%b",
             ch, mode, p, d, at, led, tick);
    if (!hold) cfg_valid = 1'b0;
  endtask

  initial begin
    int a1;
    int a2;
    reset = 1'b1; cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0;

    // Reset for two cycles, then default blink with period 3
    step();
    step();
    model_reset();
    chk("reset_led", led, 5'b11111);
    chk("reset_tick", tick, 0);
    chk("reset_ready", cfg_ready, 1);
    reset = 1'b0;
    idle(9);

    // Reprogram ch1 to BLINK P=2; other channels keep phase
    write(1, 2, 2, 0, 1'b0, a1);
    chk("ch1_led_at_accept", led[1], 1);
    step();
    chk("ready_back_high", cfg_ready, 1);
    check_all();
    idle(9);

    // Back-to-back OFF then ON with valid held; second accepted 2 cycles later
    write(0, 0, 0, 0, 1'b1, a1);
    write(2, 1, 0, 0, 1'b0, a2);
    chk("b2b_gap", a2 - a1, 2);
    idle(6);
    write(CHANNELS, 1, 1, 0, 1'b0, a1);
    idle(4);

    // Mode 11 on ch3: PWM 1,1,0,0,0 when enabled, else blink
    write(3, 3, 4, 2, 1'b0, a1);
    idle(11);
    write(3, 3, 4, 0, 1'b0, a1);
    idle(6);
    write(3, 3, 4, 7, 1'b0, a1);
    idle(6);

    // All-ones period wraps cleanly
    write(4, 2, 15, 0, 1'b0, a1);
    idle(34);

    // Write ch1 exactly when its count reaches P
    for (int w = 0; w < 6 && ((t - m_t0[1]) % 3) != 2; w++) begin
      step();
      check_all();
    end
    write(1, 2, 5, 0, 1'b0, a1);
    chk("no_tick_on_write", tick[1], 0);
    idle(7);

    // Reset mid-frame with a write pending; the write is dropped
    write(3, 3, 4, 3, 1'b0, a1);
    idle(2);
    cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_mode = 2'b01;
    reset = 1'b1;
    step();
    model_reset();
    chk("midreset_led", led, 5'b11111);
    chk("midreset_ready", cfg_ready, 1);
    check_all();
    reset = 1'b0; cfg_valid = 1'b0;
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
